instr_fetch_issue: RTL and testbench
====================================

Name: instr_fetch_issue

Overview:
- Upstream front end for the 4-stage register-bank/ALU pipeline.
- Holds a loadable program store and steps a program counter through it.
- Decodes each 24-bit instruction word into the rs1/rs2/rd/func/addr fields that the pipeline's stage-1 latch consumes.
- Stalls issue on read-after-write hazards against recently issued destinations, and stops on a HALT opcode.

Parameters:
- PROG_DEPTH, 256, program store depth in words; PC width is log2(PROG_DEPTH) = 8.
- HAZARD_DIST, 3, number of clk cycles after issue during which an instruction's rd counts as in flight.
- HALT_FUNC, 4'hF, func code treated as HALT; never issued downstream.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins execution at PC 0 from IDLE or HALT
- prog_we  in  1  program store write enable
- prog_waddr  in  8  program store write address
- prog_wdata  in  24  instruction word {func[23:20], rd[19:16], rs1[15:12], rs2[11:8], addr[7:0]}
- issue_ready  in  1  downstream accepts an instruction this cycle
- issue_valid  out  1  rs1/rs2/rd/func/addr are valid and hazard-free
- rs1, rs2, rd, func  out  4 each  decoded fields, registered
- addr  out  8  decoded memory address field
- pc  out  8  current program counter
- busy  out  1  state is FETCH or ISSUE
- halted  out  1  state is HALT
- issue_count  out  16  instructions issued since the last start, saturating at 16'hFFFF

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; pc=0; all decoded outputs 0; issue_valid=0; busy=0; halted=0; issue_count=0; scoreboard cleared.
  - Program store contents are not reset.
  - Reset asserted mid-operation aborts immediately; no partial issue.
- Program store:
  - Synchronous write when prog_we=1 and busy=0.
  - Writes while busy=1 are ignored.
  - Synchronous read, 1-cycle latency.
- FSM states: IDLE, FETCH, ISSUE, HALT.
- IDLE / HALT:
  - start=1 -> pc=0, issue_count=0, scoreboard cleared, go to FETCH.
  - Otherwise hold.
- FETCH: read the store at pc, go to ISSUE next cycle.
- ISSUE: the instruction register holds the word fetched at pc; the output fields are driven from it.
  - If func==HALT_FUNC: issue_valid=0, go to HALT next cycle; pc holds the HALT location.
  - Else hazard = (rs1 or rs2 equals the rd of any live scoreboard entry).
  - issue_valid = !hazard.
  - fire = issue_valid & issue_ready.
  - On fire: push rd into the scoreboard, issue_count+1 (saturating), pc = pc+1 (wraps 255->0 and continues), go to FETCH.
  - No fire: remain in ISSUE with fields stable.
- Throughput: one instruction per 2 cycles max (FETCH+ISSUE). Issue latency from start is 2 cycles.
- Scoreboard: HAZARD_DIST entries {valid, rd}.
  - Each cycle every entry ages by one and the oldest drops out, so an rd is live for exactly HAZARD_DIST cycles after its fire.
  - The hazard check is conservative: both sources are checked regardless of func.
- Simultaneous events:
  - start while busy is ignored.
  - prog_we together with start from IDLE: the write completes and start proceeds. Same-address fetch reads the pre-write data only if the same-cycle read-before-write rule applies; the store is read-first.
- Downstream contract: the fields hold stable while issue_valid=1 and issue_ready=0.

Optional Feature:
- HAZARD_STALL_EN
- Defined: scoreboard present and RAW stalls applied as above.
- Undefined: no scoreboard; hazard is constant 0, so issue_valid=1 in every non-HALT ISSUE cycle. Software must insert independent instructions.

Decomposition:
- Shared package if_pkg holds:
  - instruction field bit positions
  - INSTR_W=24
  - the HALT_FUNC value
  - FSM state enum {IDLE, FETCH, ISSUE, HALT}
  - ALU func code constants 0..11 shared with the ALU stage
- One sub-module: hazard_scoreboard (shift-register of {valid, rd}; inputs push/rd/rs1/rs2, output hazard).

Test Plan:
- Load [0]={0,1,2,3,00}, [1]={F,...}; pulse start with issue_ready=1 -> issue at cycle 2 with func=0 rd=1 rs1=2 rs2=3; halted=1 by cycle 5; issue_count=1; pc=1.
- Back-pressure: hold issue_ready=0 for 4 cycles in ISSUE -> issue_valid stays 1, fields stable, pc unchanged; release -> single issue, issue_count+1.
- RAW hazard, macro defined: [0] rd=5, [1] rs1=5 -> instr 1 has issue_valid=0 until 3 cycles after instr 0 fired, then issues. Macro undefined -> instr 1 issues 2 cycles after instr 0.
- PC wrap: fill all 256 words with non-HALT instructions -> after issuing pc=255, pc=0 and execution continues; issue_count=257 after the 257th issue.
- Async reset mid-ISSUE: rst_n low for 1 cycle -> all outputs 0 and state IDLE immediately; program contents retained; a new start re-issues word 0.
- prog_we while busy=1 to the address currently executing -> store unchanged, verified after HALT by re-running.

Source files
------------

// File: rtl/if_pkg.sv
// if_pkg: instruction format, FSM states and ALU func codes shared by instr_fetch_issue and the ALU stage
package if_pkg;
    localparam int INSTR_W    = 24;
    localparam int PROG_DEPTH = 256;
    localparam int PC_W       = $clog2(PROG_DEPTH);
    localparam int FUNC_LO    = 20;
    localparam int RD_LO      = 16;
    localparam int RS1_LO     = 12;
    localparam int RS2_LO     = 8;
    localparam int ADDR_LO    = 0;
    localparam logic [3:0] HALT_FUNC = 4'hF;

    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALT} state_t;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_AND    = 4'd2;
    localparam logic [3:0] ALU_OR     = 4'd3;
    localparam logic [3:0] ALU_XOR    = 4'd4;
    localparam logic [3:0] ALU_NOT    = 4'd5;
    localparam logic [3:0] ALU_SHL    = 4'd6;
    localparam logic [3:0] ALU_SHR    = 4'd7;
    localparam logic [3:0] ALU_PASS_A = 4'd8;
    localparam logic [3:0] ALU_PASS_B = 4'd9;
    localparam logic [3:0] ALU_LOAD   = 4'd10;
    localparam logic [3:0] ALU_STORE  = 4'd11;

    function automatic logic [3:0] nib(input logic [INSTR_W-1:0] w, input int lo);
        return w[lo +: 4];
    endfunction
endpackage

// File: rtl/instr_fetch_issue_hazard_scoreboard.sv
// hazard_scoreboard: RAW check against recently issued rd values; stall logic exists only with HAZARD_STALL_EN
module hazard_scoreboard #(
    parameter int DEPTH = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clr,
    input  logic       i_push,
    input  logic [3:0] i_rd,
    input  logic [3:0] i_rs1,
    input  logic [3:0] i_rs2,
    output logic       o_hazard
);
`ifdef HAZARD_STALL_EN
    logic [DEPTH-1:0] r_v;
    logic [3:0]       r_rd [DEPTH];

    // Shifts every cycle, so an rd stays live for exactly DEPTH cycles after its push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v <= '0;
            for (int i = 0; i < DEPTH; i++) r_rd[i] <= '0;
        end else begin
            r_v <= i_clr ? '0 : {r_v[DEPTH-2:0], i_push};
            r_rd[0] <= i_rd;
            for (int i = 1; i < DEPTH; i++) r_rd[i] <= r_rd[i-1];
        end
    end

    always_comb begin
        o_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            o_hazard = o_hazard | (r_v[i] && (r_rd[i] == i_rs1 || r_rd[i] == i_rs2));
    end
`else
    logic w_unused;
    assign w_unused = ^{clk, rst_n, i_clr, i_push, i_rd, i_rs1, i_rs2};
    assign o_hazard = 1'b0;
`endif
endmodule

// File: rtl/instr_fetch_issue.sv
// instr_fetch_issue: program store, PC sequencer and hazard-gated issue; HAZARD_STALL_EN enables RAW stalls
module instr_fetch_issue
    import if_pkg::*;
#(
    parameter int HAZARD_DIST = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               prog_we,
    input  logic [PC_W-1:0]    prog_waddr,
    input  logic [INSTR_W-1:0] prog_wdata,
    input  logic               issue_ready,
    output logic               issue_valid,
    output logic [3:0]         rs1,
    output logic [3:0]         rs2,
    output logic [3:0]         rd,
    output logic [3:0]         func,
    output logic [7:0]         addr,
    output logic [PC_W-1:0]    pc,
    output logic               busy,
    output logic               halted,
    output logic [15:0]        issue_count
);
    logic [INSTR_W-1:0] r_mem [PROG_DEPTH];
    logic [INSTR_W-1:0] r_ir;
    state_t             r_state;
    logic [PC_W-1:0]    r_pc;
    logic [15:0]        r_count;
    logic               w_busy, w_is_halt, w_hazard, w_valid, w_fire, w_clr;

    assign w_busy    = r_state == FETCH || r_state == ISSUE;
    assign w_is_halt = nib(r_ir, FUNC_LO) == HALT_FUNC;
    assign w_valid   = r_state == ISSUE && !w_is_halt && !w_hazard;
    assign w_fire    = w_valid && issue_ready;
    assign w_clr     = start && !w_busy;

    assign func        = nib(r_ir, FUNC_LO);
    assign rd          = nib(r_ir, RD_LO);
    assign rs1         = nib(r_ir, RS1_LO);
    assign rs2         = nib(r_ir, RS2_LO);
    assign addr        = r_ir[ADDR_LO +: 8];
    assign issue_valid = w_valid;
    assign pc          = r_pc;
    assign busy        = w_busy;
    assign halted      = r_state == HALT;
    assign issue_count = r_count;

    // Store contents survive reset; writes are locked out while a program runs.
    always_ff @(posedge clk) begin
        if (prog_we && !w_busy) r_mem[prog_waddr] <= prog_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_pc    <= '0;
            r_ir    <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                IDLE, HALT: begin
                    if (start) begin
                        r_state <= FETCH;
                        r_pc    <= '0;
                        r_count <= '0;
                    end
                end
                FETCH: begin
                    r_ir    <= r_mem[r_pc];
                    r_state <= ISSUE;
                end
                ISSUE: begin
                    if (w_is_halt) begin
                        r_state <= HALT;
                    end else if (w_fire) begin
                        r_pc    <= r_pc + 1'b1;
                        r_count <= r_count != 16'hFFFF ? r_count + 16'd1 : r_count;
                        r_state <= FETCH;
                    end
                end
            endcase
        end
    end

    hazard_scoreboard #(.DEPTH(HAZARD_DIST)) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_clr),
        .i_push   (w_fire),
        .i_rd     (rd),
        .i_rs1    (rs1),
        .i_rs2    (rs2),
        .o_hazard (w_hazard)
    );
endmodule

// File: tb/tb_instr_fetch_issue.sv
// tb_instr_fetch_issue: directed and randomized checks of instr_fetch_issue against a timestamp-based model
module tb_instr_fetch_issue;
`ifdef HAZARD_STALL_EN
    localparam int HD = 3;
    localparam int EXP_GAP = 4;
`else
    localparam int EXP_GAP = 2;
`endif
    localparam logic [23:0] HALT_W = 24'hF00000;

    logic        clk = 0, rst_n = 0, start = 0, prog_we = 0, issue_ready = 0;
    logic [7:0]  prog_waddr = 0;
    logic [23:0] prog_wdata = 0;
    logic        issue_valid, busy, halted;
    logic [3:0]  rs1, rs2, rd, func;
    logic [7:0]  addr, pc;
    logic [15:0] issue_count;
    int          n_checks = 0, n_errors = 0;
    bit          chk_en = 0;

    instr_fetch_issue dut (
        .clk(clk), .rst_n(rst_n), .start(start), .prog_we(prog_we), .prog_waddr(prog_waddr),
        .prog_wdata(prog_wdata), .issue_ready(issue_ready), .issue_valid(issue_valid),
        .rs1(rs1), .rs2(rs2), .rd(rd), .func(func), .addr(addr), .pc(pc), .busy(busy),
        .halted(halted), .issue_count(issue_count)
    );

    always #5 clk = ~clk;

    // Reference: mode 0 idle, 1 fetching, 2 issuing, 3 halted; hazards come from per-register fire timestamps.
    logic [23:0] m_mem [256];
    logic [23:0] m_word;
    int          m_mode, m_pc, m_cnt, m_cyc;
    int          m_last [16];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit m_haz();
`ifdef HAZARD_STALL_EN
        int a = m_cyc - m_last[m_word[15:12]];
        int b = m_cyc - m_last[m_word[11:8]];
        return (a >= 1 && a <= HD) || (b >= 1 && b <= HD);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_valid();
        return m_mode == 2 && m_word[23:20] != 4'hF && !m_haz();
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 16; i++) m_last[i] = -100;
    endtask

    task automatic m_reset();
        m_mode = 0; m_pc = 0; m_cnt = 0; m_word = '0;
        m_clear();
    endtask

    task automatic m_step();
        bit f = m_valid() && issue_ready;
        bit b = m_mode == 1 || m_mode == 2;
        if (m_mode == 0 || m_mode == 3) begin
            if (start) begin
                m_mode = 1; m_pc = 0; m_cnt = 0;
                m_clear();
            end
        end else if (m_mode == 1) begin
            m_word = m_mem[m_pc];
            m_mode = 2;
        end else if (m_word[23:20] == 4'hF) begin
            m_mode = 3;
        end else if (f) begin
            m_last[m_word[19:16]] = m_cyc;
            m_pc  = (m_pc + 1) % 256;
            m_cnt = m_cnt == 65535 ? m_cnt : m_cnt + 1;
            m_mode = 1;
        end
        if (prog_we && !b) m_mem[prog_waddr] = prog_wdata;
        m_cyc++;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_reset();
        else m_step();
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("issue_valid", issue_valid, m_valid());
            chk("busy", busy, m_mode == 1 || m_mode == 2);
            chk("halted", halted, m_mode == 3);
            chk("pc", pc, m_pc);
            chk("issue_count", issue_count, m_cnt);
            chk("func", func, m_word[23:20]);
            chk("rd", rd, m_word[19:16]);
            chk("rs1", rs1, m_word[15:12]);
            chk("rs2", rs2, m_word[11:8]);
            chk("addr", addr, m_word[7:0]);
        end
    end

    function automatic logic [23:0] mk(input int f, input int d, input int s1, input int s2, input int ad);
        return {f[3:0], d[3:0], s1[3:0], s2[3:0], ad[7:0]};
    endfunction

    function automatic logic [23:0] rnd_word();
        return mk($urandom_range(0, 11), $urandom_range(0, 15), $urandom_range(0, 15),
                  $urandom_range(0, 15), $urandom_range(0, 255));
    endfunction

    task automatic wr(input int a, input logic [23:0] d);
        @(negedge clk);
        prog_we = 1; prog_waddr = a[7:0]; prog_wdata = d;
        @(negedge clk);
        prog_we = 0;
    endtask

    task automatic go();
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_halt(input int budget, input bit rnd);
        for (int i = 0; i < budget && !halted; i++) begin
            @(negedge clk);
            if (rnd) begin
                issue_ready = $urandom_range(0, 3) != 0;
                start = !halted && $urandom_range(0, 15) == 0;
            end
        end
        start = 0;
        issue_ready = 1;
        chk("halt_reached", halted, 1);
    endtask

    initial begin
        int t0, t1, hp;
        logic [23:0] prog0;
        for (int i = 0; i < 256; i++) m_mem[i] = '0;
        m_cyc = 0;
        m_reset();
        repeat (2) @(negedge clk);
        chk("rst_valid", issue_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_pc", pc, 0);
        chk("rst_count", issue_count, 0);
        chk("rst_fields", {func, rd, rs1, rs2, addr}, 0);
        rst_n = 1;
        chk_en = 1;

        // Basic issue then HALT
        wr(0, mk(0, 1, 2, 3, 0));
        wr(1, HALT_W);
        issue_ready = 1;
        go();
        @(negedge clk);
        chk("t1_valid", issue_valid, 1);
        chk("t1_func", func, 0);
        chk("t1_rd", rd, 1);
        chk("t1_rs1", rs1, 2);
        chk("t1_rs2", rs2, 3);
        repeat (3) @(negedge clk);
        chk("t1_halted", halted, 1);
        chk("t1_count", issue_count, 1);
        chk("t1_pc", pc, 1);

        // Back-pressure holds the instruction
        wr(0, mk(1, 2, 3, 4, 'h55));
        wr(1, HALT_W);
        issue_ready = 0;
        go();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_valid", issue_valid, 1);
            chk("bp_addr", addr, 'h55);
            chk("bp_rd", rd, 2);
            chk("bp_pc", pc, 0);
            chk("bp_count0", issue_count, 0);
        end
        issue_ready = 1;
        @(negedge clk);
        chk("bp_count1", issue_count, 1);
        chk("bp_after", issue_valid, 0);
        wait_halt(20, 0);
        chk("bp_final", issue_count, 1);

        // RAW distance between dependent instructions
        wr(0, mk(0, 5, 1, 2, 0));
        wr(1, mk(0, 6, 5, 3, 0));
        wr(2, HALT_W);
        go();
        t0 = -1; t1 = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (issue_valid) begin
                if (t0 < 0) t0 = i;
                else if (t1 < 0) t1 = i;
            end
        end
        chk("raw_first", t0, 0);
        chk("raw_gap", t1 - t0, EXP_GAP);

        // Writes while busy are ignored
        wr(0, mk(2, 7, 1, 1, 'hA0));
        wr(1, HALT_W);
        go();
        for (int i = 0; i < 20 && !halted; i++) begin
            prog_we = 1; prog_waddr = 0; prog_wdata = mk(3, 9, 9, 9, 'hFF);
            @(negedge clk);
        end
        prog_we = 0;
        chk("bw_halted", halted, 1);
        go();
        @(negedge clk);
        chk("bw_func", func, 2);
        chk("bw_rd", rd, 7);
        chk("bw_addr", addr, 'hA0);
        wait_halt(20, 0);

        // Random programs with random back-pressure and ignored start pulses
        for (int r = 0; r < 3; r++) begin
            hp = $urandom_range(3, 39);
            for (int a = 0; a < 40; a++) wr(a, a == hp ? HALT_W : rnd_word());
            go();
            wait_halt(2000, 1);
            chk("rand_halt_pc", pc, hp);
            chk("rand_count", issue_count, hp);
        end

        // PC wrap over a full store
        for (int a = 0; a < 256; a++) begin
            logic [23:0] w = rnd_word();
            if (a == 0) prog0 = w;
            wr(a, w);
        end
        go();
        for (int i = 0; i < 20000 && issue_count != 257; i++) begin
            @(negedge clk);
            if (issue_count != 257) issue_ready = $urandom_range(0, 3) != 0;
        end
        chk("wrap_count", issue_count, 257);
        chk("wrap_pc", pc, 1);
        issue_ready = 1;

        // Async reset in ISSUE, then restart from word 0
        for (int i = 0; i < 20 && !issue_valid; i++) @(negedge clk);
        chk("pre_rst_issue", issue_valid, 1);
        #2 rst_n = 0;
        #1;
        chk("arst_valid", issue_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_halted", halted, 0);
        chk("arst_pc", pc, 0);
        chk("arst_count", issue_count, 0);
        chk("arst_fields", {func, rd, rs1, rs2, addr}, 0);
        @(negedge clk);
        rst_n = 1;
        go();
        @(negedge clk);
        chk("rerun_valid", issue_valid, 1);
        chk("rerun_word", {func, rd, rs1, rs2, addr}, prog0);
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
